// File: rtl/mcc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mcc_pkg                                                         |
// | Purpose  : Shared constants for the multicycle control unit: opcode        |
// |            values, FSM state encoding, ALUOp encoding and opcode-class     |
// |            helper functions.                                               |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mcc_pkg;

   // Opcodes
   localparam logic [5:0] c_OP_ADD  = 6'b000000;
   localparam logic [5:0] c_OP_SUB  = 6'b000001;
   localparam logic [5:0] c_OP_ADDI = 6'b000010;
   localparam logic [5:0] c_OP_OR   = 6'b010000;
   localparam logic [5:0] c_OP_AND  = 6'b010001;
   localparam logic [5:0] c_OP_ORI  = 6'b010010;
   localparam logic [5:0] c_OP_SLL  = 6'b011000;
   localparam logic [5:0] c_OP_SLT  = 6'b100110;
   localparam logic [5:0] c_OP_SLTI = 6'b100111;
   localparam logic [5:0] c_OP_SW   = 6'b110000;
   localparam logic [5:0] c_OP_LW   = 6'b110001;
   localparam logic [5:0] c_OP_BEQ  = 6'b110100;
   localparam logic [5:0] c_OP_BNE  = 6'b110101;
   localparam logic [5:0] c_OP_BGTZ = 6'b110110;
   localparam logic [5:0] c_OP_J    = 6'b111000;
   localparam logic [5:0] c_OP_JR   = 6'b111001;
   localparam logic [5:0] c_OP_JAL  = 6'b111010;
   localparam logic [5:0] c_OP_HALT = 6'b111111;

   // ALU function codes
   localparam logic [2:0] c_ALU_ADD = 3'b000;
   localparam logic [2:0] c_ALU_SUB = 3'b001;
   localparam logic [2:0] c_ALU_SLT = 3'b011;
   localparam logic [2:0] c_ALU_SLL = 3'b100;
   localparam logic [2:0] c_ALU_OR  = 3'b101;
   localparam logic [2:0] c_ALU_AND = 3'b110;

   // Controller states; the encoding is visible on the state output
   typedef enum logic [2:0] {
      ST_IF   = 3'b000,
      ST_ID   = 3'b001,
      ST_EXE  = 3'b010,
      ST_WB   = 3'b011,
      ST_MEM  = 3'b100,
      ST_HALT = 3'b101,
      ST_ERR  = 3'b110
   } state_t;

   function automatic logic f_is_jump(input logic [5:0] op);
      return (op == c_OP_J) || (op == c_OP_JR) || (op == c_OP_JAL);
   endfunction

   function automatic logic f_is_branch(input logic [5:0] op);
      return (op == c_OP_BEQ) || (op == c_OP_BNE) || (op == c_OP_BGTZ);
   endfunction

   function automatic logic f_is_mem(input logic [5:0] op);
      return (op == c_OP_LW) || (op == c_OP_SW);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mcc_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mcc_decode                                                      |
// | Purpose  : Purely combinational opcode-to-select decoder for the           |
// |            multicycle controller.                                          |
// | Ports    : i_op[5:0]        opcode from IR                                 |
// |            i_zero, i_sign   ALU flags (branch resolution)                  |
// |            o_pc_src[1:0]    next-PC select                                 |
// |            o_ext_sel        immediate sign-extend (0 = zero-extend)        |
// |            o_reg_dst[1:0]   destination register select                    |
// |            o_wr_reg_d_src   write-data source (0 = return address)         |
// |            o_alu_src_a/b    ALU operand selects                            |
// |            o_alu_op[2:0]    ALU function                                   |
// |            o_illegal        opcode is not in the instruction set           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mcc_decode
   import mcc_pkg::*;
(
   input  logic [5:0] i_op,
   input  logic       i_zero,
   input  logic       i_sign,
   output logic [1:0] o_pc_src,
   output logic       o_ext_sel,
   output logic [1:0] o_reg_dst,
   output logic       o_wr_reg_d_src,
   output logic       o_alu_src_a,
   output logic       o_alu_src_b,
   output logic [2:0] o_alu_op,
   output logic       o_illegal
);

   always_comb begin
      o_pc_src       = 2'b00;
      o_ext_sel      = 1'b1;
      o_reg_dst      = 2'b10;
      o_wr_reg_d_src = 1'b1;
      o_alu_src_a    = 1'b0;
      o_alu_src_b    = 1'b0;
      o_alu_op       = c_ALU_ADD;
      o_illegal      = 1'b0;
      case (i_op)
         c_OP_ADD, c_OP_HALT, c_OP_SW: begin
            o_alu_src_b = (i_op == c_OP_SW);
         end
         c_OP_SUB:  o_alu_op = c_ALU_SUB;
         c_OP_ADDI: begin
            o_reg_dst   = 2'b01;
            o_alu_src_b = 1'b1;
         end
         c_OP_OR:   o_alu_op = c_ALU_OR;
         c_OP_AND:  o_alu_op = c_ALU_AND;
         c_OP_ORI: begin
            o_ext_sel   = 1'b0;
            o_reg_dst   = 2'b01;
            o_alu_src_b = 1'b1;
            o_alu_op    = c_ALU_OR;
         end
         c_OP_SLL: begin
            o_alu_src_a = 1'b1;
            o_alu_op    = c_ALU_SLL;
         end
         c_OP_SLT:  o_alu_op = c_ALU_SLT;
         c_OP_SLTI: begin
            o_reg_dst   = 2'b01;
            o_alu_src_b = 1'b1;
            o_alu_op    = c_ALU_SLT;
         end
         c_OP_LW: begin
            o_reg_dst   = 2'b01;
            o_alu_src_b = 1'b1;
         end
         // Branches compare via subtraction; the flags pick taken/not-taken
         c_OP_BEQ: begin
            o_alu_op = c_ALU_SUB;
            o_pc_src = i_zero ? 2'b01 : 2'b00;
         end
         c_OP_BNE: begin
            o_alu_op = c_ALU_SUB;
            o_pc_src = !i_zero ? 2'b01 : 2'b00;
         end
         c_OP_BGTZ: begin
            o_alu_op = c_ALU_SUB;
            o_pc_src = (!i_zero && !i_sign) ? 2'b01 : 2'b00;
         end
         c_OP_J:    o_pc_src = 2'b11;
         c_OP_JR:   o_pc_src = 2'b10;
         c_OP_JAL: begin
            o_pc_src       = 2'b11;
            o_reg_dst      = 2'b00;
            o_wr_reg_d_src = 1'b0;
         end
         default:   o_illegal = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multicycle_ctrl                                                 |
// | Purpose  : Multicycle CPU control unit. Sequences IF/ID/EXE/MEM/WB per     |
// |            opcode with ready-qualified memory handshakes, a terminal HALT  |
// |            state, illegal-opcode trapping and a retired-instruction count. |
// | Config   : MCC_BUS_TIMEOUT_EN - when defined, 2^TMO_W-1 consecutive wait   |
// |            cycles in IF or MEM send the controller to the terminal ERR     |
// |            state. When undefined, waits are unbounded and bus_err is 0.    |
// | Ports    : CLK, Reset_n (async, active-low)                                |
// |            opCode[5:0], zero, sign        IR opcode and ALU flags          |
// |            imem_ready, dmem_ready         memory completion handshakes     |
// |            PCWre, IRWre, RegWre           write enables                    |
// |            ALUSrcA/B, DBDataSrc, WrRegDSrc, ExtSel, PCSrc, RegDst, ALUOp    |
// |                                           datapath selects                 |
// |            imem_req, dmem_rd, dmem_wr     memory requests                  |
// |            state[2:0], halted, ill_op, bus_err, instr_cnt[CNT_W-1:0]       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module multicycle_ctrl
   import mcc_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int TMO_W = 4
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic [5:0]       opCode,
   input  logic             zero,
   input  logic             sign,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             PCWre,
   output logic             IRWre,
   output logic             RegWre,
   output logic             ALUSrcA,
   output logic             ALUSrcB,
   output logic             DBDataSrc,
   output logic             WrRegDSrc,
   output logic             ExtSel,
   output logic [1:0]       PCSrc,
   output logic [1:0]       RegDst,
   output logic [2:0]       ALUOp,
   output logic             imem_req,
   output logic             dmem_rd,
   output logic             dmem_wr,
   output logic [2:0]       state,
   output logic             halted,
   output logic             ill_op,
   output logic             bus_err,
   output logic [CNT_W-1:0] instr_cnt
);

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_instr_cnt;
   logic             w_illegal;
   logic             w_imem_req, w_irwre, w_pcwre, w_regwre;
   logic             w_dmem_rd, w_dmem_wr, w_ill_op, w_halted, w_bus_err;
   logic             w_is_lw, w_is_sw;

   assign w_is_lw = (opCode == c_OP_LW);
   assign w_is_sw = (opCode == c_OP_SW);

   mcc_decode u_decode (
      .i_op           (opCode),
      .i_zero         (zero),
      .i_sign         (sign),
      .o_pc_src       (PCSrc),
      .o_ext_sel      (ExtSel),
      .o_reg_dst      (RegDst),
      .o_wr_reg_d_src (WrRegDSrc),
      .o_alu_src_a    (ALUSrcA),
      .o_alu_src_b    (ALUSrcB),
      .o_alu_op       (ALUOp),
      .o_illegal      (w_illegal)
   );

`ifdef MCC_BUS_TIMEOUT_EN
   // Bus timeout: counts consecutive stalled cycles in IF/MEM. Expiry fires
   // on the stalled cycle whose count is one below the limit, so exactly
   // 2^TMO_W-1 wait cycles are tolerated before ERR.
   localparam logic [TMO_W-1:0] c_TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

   logic [TMO_W-1:0] r_tmo;
   logic             w_waiting;
   logic             w_tmo_expire;

   assign w_waiting    = ((r_state == ST_IF)  && !imem_ready) ||
                         ((r_state == ST_MEM) && !dmem_ready);
   assign w_tmo_expire = w_waiting && (r_tmo == c_TMO_LAST);

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_tmo <= '0;
      end else if (w_waiting && (w_next_state == r_state)) begin
         r_tmo <= r_tmo + TMO_W'(1);
      end else begin
         r_tmo <= '0;
      end
   end
`else
   // Timeout width has no effect when the timeout feature is compiled out
   logic w_unused_tmo_w;
   assign w_unused_tmo_w = (TMO_W > 0);
`endif

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= ST_IF;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_imem_req   = 1'b0;
      w_irwre      = 1'b0;
      w_pcwre      = 1'b0;
      w_regwre     = 1'b0;
      w_dmem_rd    = 1'b0;
      w_dmem_wr    = 1'b0;
      w_ill_op     = 1'b0;
      w_halted     = 1'b0;
      w_bus_err    = 1'b0;
      case (r_state)
         ST_IF: begin
            w_imem_req = 1'b1;
            if (imem_ready) begin
               w_irwre      = 1'b1;
               w_next_state = ST_ID;
            end
         end
         ST_ID: begin
            if (f_is_jump(opCode)) begin
               // Jumps retire here; jal also writes the link register now
               w_pcwre      = 1'b1;
               w_regwre     = (opCode == c_OP_JAL);
               w_next_state = ST_IF;
            end else if (opCode == c_OP_HALT) begin
               w_next_state = ST_HALT;
            end else if (w_illegal) begin
               // Trap: skip the instruction and continue fetching
               w_pcwre      = 1'b1;
               w_ill_op     = 1'b1;
               w_next_state = ST_IF;
            end else begin
               w_next_state = ST_EXE;
            end
         end
         ST_EXE: begin
            if (f_is_branch(opCode)) begin
               w_pcwre      = 1'b1;
               w_next_state = ST_IF;
            end else if (f_is_mem(opCode)) begin
               w_next_state = ST_MEM;
            end else begin
               w_next_state = ST_WB;
            end
         end
         ST_MEM: begin
            w_dmem_rd = w_is_lw;
            w_dmem_wr = w_is_sw;
            if (dmem_ready) begin
               if (w_is_sw) begin
                  w_pcwre      = 1'b1;
                  w_next_state = ST_IF;
               end else begin
                  w_next_state = ST_WB;
               end
            end
         end
         ST_WB: begin
            w_pcwre      = 1'b1;
            w_regwre     = 1'b1;
            w_next_state = ST_IF;
         end
         ST_HALT: w_halted  = 1'b1;
         ST_ERR:  w_bus_err = 1'b1;
         default: w_next_state = ST_IF;
      endcase
`ifdef MCC_BUS_TIMEOUT_EN
      if (w_tmo_expire) begin
         w_next_state = ST_ERR;
      end
`endif
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_instr_cnt <= '0;
      end else if (w_pcwre) begin
         r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      end
   end

   // The state register resets to IF, which would otherwise raise imem_req;
   // gating with Reset_n keeps every strobe low for as long as reset is held
   // and drops in-flight requests the moment reset asserts.
   assign imem_req  = w_imem_req & Reset_n;
   assign IRWre     = w_irwre    & Reset_n;
   assign PCWre     = w_pcwre    & Reset_n;
   assign RegWre    = w_regwre   & Reset_n;
   assign dmem_rd   = w_dmem_rd  & Reset_n;
   assign dmem_wr   = w_dmem_wr  & Reset_n;
   assign ill_op    = w_ill_op   & Reset_n;
   assign halted    = w_halted   & Reset_n;
`ifdef MCC_BUS_TIMEOUT_EN
   assign bus_err   = w_bus_err  & Reset_n;
`else
   assign bus_err   = 1'b0;
   logic w_unused_bus_err;
   assign w_unused_bus_err = w_bus_err;
`endif

   assign DBDataSrc = w_is_lw && ((r_state == ST_MEM) || (r_state == ST_WB));
   assign state     = r_state;
   assign instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_multicycle_ctrl                                              |
// | Purpose  : Self-checking bench for multicycle_ctrl. A planner expands each |
// |            instruction into a per-cycle schedule of inputs and expected    |
// |            outputs; a driver replays it and a monitor compares.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_multicycle_ctrl;

   localparam int CNT_W = 8;
   localparam int TMO_W = 4;

   localparam logic [2:0] M_IF = 3'b000, M_ID = 3'b001, M_EXE = 3'b010, M_WB = 3'b011,
                          M_MEM = 3'b100, M_HALT = 3'b101, M_ERR = 3'b110;

   logic             CLK = 1'b0;
   logic             Reset_n, zero, sign, imem_ready, dmem_ready;
   logic [5:0]       opCode;
   logic             PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel;
   logic [1:0]       PCSrc, RegDst;
   logic [2:0]       ALUOp, state;
   logic             imem_req, dmem_rd, dmem_wr, halted, ill_op, bus_err;
   logic [CNT_W-1:0] instr_cnt;

   always #5 CLK = ~CLK;

   multicycle_ctrl #(.CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
      .CLK(CLK), .Reset_n(Reset_n), .opCode(opCode), .zero(zero), .sign(sign),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc), .ExtSel(ExtSel), .PCSrc(PCSrc),
      .RegDst(RegDst), .ALUOp(ALUOp), .imem_req(imem_req), .dmem_rd(dmem_rd),
      .dmem_wr(dmem_wr), .state(state), .halted(halted), .ill_op(ill_op),
      .bus_err(bus_err), .instr_cnt(instr_cnt)
   );

   typedef enum int {K_ADD, K_SUB, K_ADDI, K_OR, K_AND, K_ORI, K_SLL, K_SLT, K_SLTI,
                     K_SW, K_LW, K_BEQ, K_BNE, K_BGTZ, K_J, K_JR, K_JAL, K_HALT, K_ILL} kind_t;

   logic [5:0] op_tab [0:17] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                                 6'b010010, 6'b011000, 6'b100110, 6'b100111, 6'b110000,
                                 6'b110001, 6'b110100, 6'b110101, 6'b110110, 6'b111000,
                                 6'b111001, 6'b111010, 6'b111111};

   typedef struct {
      logic             rst_n;
      logic [5:0]       op;
      logic             z, s, ir, dr;
      logic [2:0]       st;
      logic [8:0]       strb;   // imem_req IRWre PCWre RegWre dmem_rd dmem_wr ill_op halted bus_err
      logic [11:0]      dec;    // PCSrc ALUOp RegDst ExtSel WrRegDSrc ALUSrcA ALUSrcB DBDataSrc
      logic [CNT_W-1:0] cnt;
   } cyc_t;

   cyc_t             plan_q[$];
   cyc_t             exp_q[$];
   logic [CNT_W-1:0] m_cnt = '0;
   int               n_checks = 0;
   int               n_fail = 0;

   function automatic kind_t kind_of(input logic [5:0] op);
      for (int i = 0; i < 18; i++) if (op_tab[i] == op) return kind_t'(i);
      return K_ILL;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic pick(input int f);
      return (f < 0) ? rb() : (f != 0);
   endfunction

   function automatic logic [11:0] exp_dec(input kind_t k, input logic z, input logic s,
                                           input logic [2:0] st);
      logic [1:0] pcs, rd;
      logic [2:0] alu;
      pcs = 2'b00;
      if (k == K_J || k == K_JAL)             pcs = 2'b11;
      else if (k == K_JR)                     pcs = 2'b10;
      else if (k == K_BEQ  && z)              pcs = 2'b01;
      else if (k == K_BNE  && !z)             pcs = 2'b01;
      else if (k == K_BGTZ && !z && !s)       pcs = 2'b01;
      alu = 3'b000;
      if (k inside {K_SUB, K_BEQ, K_BNE, K_BGTZ}) alu = 3'b001;
      else if (k inside {K_SLT, K_SLTI})       alu = 3'b011;
      else if (k == K_SLL)                     alu = 3'b100;
      else if (k inside {K_OR, K_ORI})         alu = 3'b101;
      else if (k == K_AND)                     alu = 3'b110;
      rd = (k == K_JAL) ? 2'b00 : (k inside {K_ADDI, K_ORI, K_SLTI, K_LW}) ? 2'b01 : 2'b10;
      return {pcs, alu, rd, (k != K_ORI), (k != K_JAL), (k == K_SLL),
              (k inside {K_ADDI, K_ORI, K_SLTI, K_LW, K_SW}),
              (k == K_LW && (st == M_MEM || st == M_WB))};
   endfunction

   // One clock of the plan: inputs to drive plus the outputs the spec requires
   function automatic void push_cycle(input logic rn, input logic [2:0] st, input logic [5:0] op,
                                      input logic z, input logic s, input logic ir, input logic dr);
      cyc_t  c;
      kind_t k = kind_of(op);
      logic  imq = 0, irw = 0, pcw = 0, rgw = 0, drd = 0, dwr = 0, ill = 0, hlt = 0, ber = 0;
      c.rst_n = rn; c.op = op; c.z = z; c.s = s; c.ir = ir; c.dr = dr;
      if (!rn) begin
         m_cnt = '0;
         c.st  = M_IF;
      end else begin
         c.st = st;
         case (st)
            M_IF:   begin imq = 1; irw = ir; end
            M_ID:   begin pcw = (k inside {K_J, K_JR, K_JAL, K_ILL}); rgw = (k == K_JAL);
                          ill = (k == K_ILL); end
            M_EXE:  pcw = (k inside {K_BEQ, K_BNE, K_BGTZ});
            M_MEM:  begin drd = (k == K_LW); dwr = (k == K_SW); pcw = (k == K_SW) && dr; end
            M_WB:   begin pcw = 1; rgw = 1; end
            M_HALT: hlt = 1;
            M_ERR:  ber = 1;
            default: ;
         endcase
      end
      c.strb = {imq, irw, pcw, rgw, drd, dwr, ill, hlt, ber};
      c.dec  = exp_dec(k, z, s, c.st);
      c.cnt  = m_cnt;
      if (pcw) m_cnt = m_cnt + 1'b1;
      plan_q.push_back(c);
   endfunction

   function automatic void push_reset(input int n);
      for (int i = 0; i < n; i++)
         push_cycle(1'b0, M_IF, 6'($urandom_range(0, 63)), rb(), rb(), rb(), rb());
   endfunction

   // Expand one instruction into its cycle sequence: iw/dw wait cycles,
   // fz/fs force zero/sign (-1 = random), abort_mem>0 resets inside MEM.
   function automatic void add_instr(input logic [5:0] op, input int iw, input int dw,
                                     input int fz, input int fs, input int abort_mem);
      kind_t k = kind_of(op);
      for (int i = 0; i <= iw; i++) push_cycle(1, M_IF, op, pick(fz), pick(fs), (i == iw), rb());
      push_cycle(1, M_ID, op, pick(fz), pick(fs), rb(), rb());
      if (k == K_HALT) begin
         for (int i = 0; i < 20; i++) push_cycle(1, M_HALT, op, rb(), rb(), rb(), rb());
         push_reset(2);
         return;
      end
      if (k inside {K_J, K_JR, K_JAL, K_ILL}) return;
      push_cycle(1, M_EXE, op, pick(fz), pick(fs), rb(), rb());
      if (k inside {K_BEQ, K_BNE, K_BGTZ}) return;
      if (k == K_LW || k == K_SW) begin
         for (int i = 0; i <= dw; i++) begin
            if (abort_mem > 0 && i == abort_mem) begin
               push_reset(2);
               return;
            end
            push_cycle(1, M_MEM, op, pick(fz), pick(fs), rb(), (i == dw));
         end
         if (k == K_SW) return;
      end
      push_cycle(1, M_WB, op, pick(fz), pick(fs), rb(), rb());
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, idx, act, expv);
      end
   endtask

   // Monitor: samples mid-cycle, away from the rising edge
   initial begin
      int idx = 0;
      cyc_t e;
      forever begin
         @(negedge CLK);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state", idx, 32'(state), 32'(e.st));
            check("strobes", idx, 32'({imem_req, IRWre, PCWre, RegWre, dmem_rd, dmem_wr,
                                       ill_op, halted, bus_err}), 32'(e.strb));
            check("decode", idx, 32'({PCSrc, ALUOp, RegDst, ExtSel, WrRegDSrc, ALUSrcA,
                                      ALUSrcB, DBDataSrc}), 32'(e.dec));
            check("instr_cnt", idx, 32'(instr_cnt), 32'(e.cnt));
            idx++;
         end
      end
   end

   // Planner + driver
   initial begin
      cyc_t c;
      kind_t k;
      logic [5:0] op;
      Reset_n = 1'b0; opCode = '0; zero = 0; sign = 0; imem_ready = 0; dmem_ready = 0;

      push_reset(3);
      add_instr(6'b000000, 0, 0, -1, -1, 0);   // add, zero-wait
      add_instr(6'b110001, 0, 3, -1, -1, 0);   // lw, 3 data wait cycles
      add_instr(6'b110100, 0, 0,  1, -1, 0);   // beq taken
      add_instr(6'b110110, 0, 0, -1,  1, 0);   // bgtz with sign set
      add_instr(6'b101010, 0, 0, -1, -1, 0);   // illegal opcode
      add_instr(6'b111010, 1, 0, -1, -1, 0);   // jal
      add_instr(6'b110000, 1, 3, -1, -1, 2);   // sw, reset while in MEM
      add_instr(6'b000010, 2, 0, -1, -1, 0);   // addi after reset release
      // Instruction memory never answers
`ifdef MCC_BUS_TIMEOUT_EN
      for (int i = 0; i < 15; i++) push_cycle(1, M_IF, 6'b000000, rb(), rb(), 1'b0, rb());
      for (int i = 0; i < 5; i++)  push_cycle(1, M_ERR, 6'b000000, rb(), rb(), rb(), rb());
`else
      for (int i = 0; i < 101; i++) push_cycle(1, M_IF, 6'b000000, rb(), rb(), 1'b0, rb());
`endif
      push_reset(2);
      add_instr(6'b111111, 0, 0, -1, -1, 0);   // halt
      // Random traffic; long enough for the 8-bit counter to wrap
      for (int n = 0; n < 320; n++) begin
         if ($urandom_range(0, 11) == 0) begin
            do op = 6'($urandom_range(0, 63)); while (kind_of(op) != K_ILL);
         end else begin
            k  = kind_t'($urandom_range(0, 16));
            op = op_tab[k];
         end
         add_instr(op, $urandom_range(0, 4), $urandom_range(0, 4), -1, -1, 0);
      end

      while (plan_q.size() > 0) begin
         c = plan_q.pop_front();
         @(posedge CLK);
         #1;
         Reset_n = c.rst_n; opCode = c.op; zero = c.z; sign = c.s;
         imem_ready = c.ir; dmem_ready = c.dr;
         exp_q.push_back(c);
      end
      repeat (2) @(posedge CLK);
      #1;
      check("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
